elevator_scan_ctrl: RTL and testbench



---
 rtl/elevator_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scan_ctrl.sv
// SCAN elevator controller: latches floor calls, serves them in sweep order with timed travel and door dwell.
// Outputs are registered or decoded from the registered state.
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS = 10,
    parameter int FLOOR_W    = 4,
    parameter int MOVE_TICKS = 10000000,
    parameter int DOOR_TICKS = 20000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_in,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic                  idle,
    output logic                  arrive
);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

    localparam logic [31:0]        MOVE_LAST = 32'(MOVE_TICKS - 1);
    localparam logic [31:0]        DOOR_LAST = 32'(DOOR_TICKS - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0] ONE       = FLOOR_W'(1);

    state_t                state;
    logic [31:0]           timer;
    logic [NUM_FLOORS-1:0] floor_onehot, up_onehot, down_onehot;
    logic [NUM_FLOORS-1:0] clear, call_keep;
    logic                  any_above, any_below, here_req, serve_up, serve_down;
    logic                  choose_up, choose_down, move_done, door_done, restart;

    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            floor_onehot[i] = (FLOOR_W'(i) == current_floor);
            if (pending[i] && FLOOR_W'(i) > current_floor) any_above = 1'b1;
            if (pending[i] && FLOOR_W'(i) < current_floor) any_below = 1'b1;
        end
        up_onehot   = floor_onehot << 1;
        down_onehot = floor_onehot >> 1;
        here_req    = |(pending & floor_onehot);
        serve_up    = |(pending & up_onehot);
        serve_down  = |(pending & down_onehot);
        move_done   = (timer == MOVE_LAST);
        door_done   = (timer == DOOR_LAST);
        restart     = (state == DOOR_OPEN) && (|(call_in & floor_onehot));

        // Keep sweeping the current way while anything is ahead, otherwise reverse.
        if (dir_up) begin
            choose_up   = any_above;
            choose_down = !any_above && any_below;
        end else begin
            choose_down = any_below;
            choose_up   = !any_below && any_above;
        end

        call_keep = call_in;
        if (state == DOOR_OPEN) call_keep = call_in & ~floor_onehot;

        clear = '0;
        case (state)
            IDLE:      if (here_req) clear = floor_onehot;
            MOVE_UP:   if (current_floor != TOP_FLOOR && move_done && serve_up) clear = up_onehot;
            MOVE_DOWN: if (current_floor != '0 && move_done && serve_down) clear = down_onehot;
            default:   clear = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= '0;
            current_floor <= '0;
            pending       <= '0;
            dir_up        <= 1'b1;
            arrive        <= 1'b0;
        end else begin
            arrive  <= 1'b0;
            timer   <= timer + 32'd1;
            pending <= (pending | call_keep) & ~clear;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (here_req) begin
                        state <= DOOR_OPEN;
                    end else if (choose_up) begin
                        state  <= MOVE_UP;
                        dir_up <= 1'b1;
                    end else if (choose_down) begin
                        state  <= MOVE_DOWN;
                        dir_up <= 1'b0;
                    end
                end
                MOVE_UP: begin
                    if (current_floor == TOP_FLOOR) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (move_done) begin
                        current_floor <= current_floor + ONE;
                        arrive        <= 1'b1;
                        timer         <= '0;
                        if (serve_up) state <= DOOR_OPEN;
                    end
                end
                MOVE_DOWN: begin
                    if (current_floor == '0) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (move_done) begin
                        current_floor <= current_floor - ONE;
                        arrive        <= 1'b1;
                        timer         <= '0;
                        if (serve_down) state <= DOOR_OPEN;
                    end
                end
                DOOR_OPEN: begin
                    // A call for this floor while the door is open holds it open longer.
                    if (restart) begin
                        timer <= '0;
                    end else if (door_done) begin
                        timer <= '0;
                        if (choose_up) begin
                            state  <= MOVE_UP;
                            dir_up <= 1'b1;
                        end else if (choose_down) begin
                            state  <= MOVE_DOWN;
                            dir_up <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
    assign door_open = (state == DOOR_OPEN);
    assign idle      = (state == IDLE);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: directed scenarios plus random calls checked every cycle against a countdown-based model.
module tb_elevator_scan_ctrl;

    localparam int NF = 8;
    localparam int FW = 4;
    localparam int MT = 4;
    localparam int DT = 3;
    localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NF-1:0] call_in = '0;
    logic [FW-1:0] current_floor;
    logic [NF-1:0] pending;
    logic          dir_up, moving, door_open, idle, arrive;

    always #5 clk = ~clk;

    elevator_scan_ctrl #(
        .NUM_FLOORS(NF), .FLOOR_W(FW), .MOVE_TICKS(MT), .DOOR_TICKS(DT)
    ) dut (
        .clk(clk), .rst(rst), .call_in(call_in),
        .current_floor(current_floor), .pending(pending), .dir_up(dir_up),
        .moving(moving), .door_open(door_open), .idle(idle), .arrive(arrive)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode plus cycles-left countdown, pending as a plain bit set.
    int          m_floor = 0;
    int          m_mode  = M_IDLE;
    int          m_left  = 0;
    bit          m_up    = 1'b1;
    bit          m_arrive = 1'b0;
    bit [NF-1:0] m_pend  = '0;

    always @(posedge clk) begin : ref_model
        bit [NF-1:0] calls, clr;
        bit          decide;
        int          n_above, n_below, ahead, behind;
        if (rst) begin
            m_floor = 0; m_mode = M_IDLE; m_left = 0; m_up = 1'b1; m_arrive = 1'b0; m_pend = '0;
        end else begin
            calls = call_in;
            clr = '0;
            decide = 1'b0;
            m_arrive = 1'b0;
            if (m_mode == M_DOOR) calls[m_floor] = 1'b0;
            case (m_mode)
                M_IDLE: begin
                    if (m_pend[m_floor]) begin
                        m_mode = M_DOOR; m_left = DT; clr[m_floor] = 1'b1;
                    end else decide = 1'b1;
                end
                M_UP, M_DOWN: begin
                    if ((m_mode == M_UP && m_floor == NF - 1) || (m_mode == M_DOWN && m_floor == 0)) begin
                        m_mode = M_IDLE;
                    end else begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            m_floor = m_floor + ((m_mode == M_UP) ? 1 : -1);
                            m_arrive = 1'b1;
                            m_left = MT;
                            if (m_pend[m_floor]) begin
                                m_mode = M_DOOR; m_left = DT; clr[m_floor] = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    if (call_in[m_floor]) m_left = DT;
                    else begin
                        m_left = m_left - 1;
                        if (m_left == 0) decide = 1'b1;
                    end
                end
            endcase
            if (decide) begin
                n_above = 0;
                n_below = 0;
                for (int f = 0; f < NF; f++) begin
                    if (m_pend[f] && f > m_floor) n_above++;
                    if (m_pend[f] && f < m_floor) n_below++;
                end
                ahead  = m_up ? n_above : n_below;
                behind = m_up ? n_below : n_above;
                if (ahead > 0) begin
                    m_mode = m_up ? M_UP : M_DOWN; m_left = MT;
                end else if (behind > 0) begin
                    m_up = !m_up; m_mode = m_up ? M_UP : M_DOWN; m_left = MT;
                end else m_mode = M_IDLE;
            end
            m_pend = (m_pend | calls) & ~clr;
        end
    end

    bit checking  = 1'b0;
    bit log_doors = 1'b0;
    bit watch_move = 1'b0;
    bit saw_move  = 1'b0;
    bit prev_door = 1'b0;
    int door_log[$];

    always @(negedge clk) begin
        if (checking) begin
            check("floor", int'(current_floor), m_floor);
            check("pending", int'(pending), int'(m_pend));
            check("dir_up", int'(dir_up), int'(m_up));
            check("moving", int'(moving), int'(m_mode == M_UP || m_mode == M_DOWN));
            check("door_open", int'(door_open), int'(m_mode == M_DOOR));
            check("idle", int'(idle), int'(m_mode == M_IDLE));
            check("arrive", int'(arrive), int'(m_arrive));
            check("no_overrun", int'(moving && ((dir_up && current_floor == FW'(NF - 1)) ||
                                                (!dir_up && current_floor == '0))), 0);
            if (log_doors && door_open && !prev_door) door_log.push_back(int'(current_floor));
            if (watch_move && moving) saw_move = 1'b1;
            prev_door = door_open;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_floor(input int f, input int budget);
        int k = 0;
        while (int'(current_floor) != f && k < budget) begin
            tick(1);
            k++;
        end
        check("wait_floor", int'(current_floor), f);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (!idle && k < budget) begin
            tick(1);
            k++;
        end
        check("wait_idle", int'(idle), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        int exp3[3] = '{2, 5, 1};

        // 1: reset held two cycles with random calls
        rst = 1'b1;
        call_in = NF'($urandom);
        tick(1);
        checking = 1'b1;
        call_in = NF'($urandom);
        tick(1);
        check("rst_floor", int'(current_floor), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_dir", int'(dir_up), 1);
        check("rst_idle", int'(idle), 1);
        check("rst_moving", int'(moving), 0);
        check("rst_door", int'(door_open), 0);
        check("rst_arrive", int'(arrive), 0);
        rst = 1'b0;
        call_in = '0;
        tick(1);
        check("rel_pending", int'(pending), 0);

        // 2: single call to floor 3
        call_in = 8'h08;
        tick(1);
        check("t2_pend", int'(pending), 8'h08);
        call_in = '0;
        tick(1);
        check("t2_moving", int'(moving), 1);
        tick(4);
        check("t2_f1", int'(current_floor), 1);
        tick(4);
        check("t2_f2", int'(current_floor), 2);
        tick(4);
        check("t2_f3", int'(current_floor), 3);
        check("t2_door", int'(door_open), 1);
        check("t2_pend0", int'(pending), 0);
        tick(3);
        check("t2_idle", int'(idle), 1);

        // 3: SCAN order 2, 5, then reverse to 1
        do_reset();
        log_doors = 1'b1;
        call_in = 8'h24;
        tick(1);
        call_in = '0;
        wait_floor(3, 60);
        call_in = 8'h02;
        tick(1);
        call_in = '0;
        wait_idle(200);
        log_doors = 1'b0;
        check("t3_ndoors", door_log.size(), 3);
        for (int i = 0; i < 3; i++)
            check("t3_order", (i < door_log.size()) ? door_log[i] : -1, exp3[i]);
        check("t3_dir", int'(dir_up), 0);

        // 4: call for the floor the car is idling at
        saw_move = 1'b0;
        watch_move = 1'b1;
        call_in = 8'h02;
        tick(1);
        check("t4_pend", int'(pending), 8'h02);
        call_in = '0;
        tick(1);
        check("t4_door", int'(door_open), 1);
        check("t4_pend0", int'(pending), 0);
        tick(3);
        check("t4_idle", int'(idle), 1);
        watch_move = 1'b0;
        check("t4_nomove", int'(saw_move), 0);

        // 5: call on the clearing edge is dropped; call mid-dwell restarts it
        call_in = 8'h08;
        tick(1);
        call_in = '0;
        wait_floor(2, 40);
        tick(3);
        call_in = 8'h08;
        tick(1);
        check("t5_door", int'(door_open), 1);
        check("t5_floor", int'(current_floor), 3);
        check("t5_drop", int'(pending), 0);
        call_in = '0;
        tick(1);
        call_in = 8'h08;
        tick(1);
        call_in = '0;
        check("t5_restart_pend", int'(pending), 0);
        tick(2);
        check("t5_dwell_ext", int'(door_open), 1);
        tick(1);
        check("t5_close", int'(idle), 1);

        // 6: reset while moving up past floor 4
        call_in = 8'h80;
        tick(1);
        call_in = '0;
        wait_floor(4, 40);
        check("t6_moving", int'(moving), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_floor", int'(current_floor), 0);
        check("t6_pend", int'(pending), 0);
        check("t6_idle", int'(idle), 1);
        saw_move = 1'b0;
        watch_move = 1'b1;
        tick(20);
        watch_move = 1'b0;
        check("t6_still", int'(saw_move), 0);

        // Random traffic with occasional resets, checked by the model each cycle
        for (int c = 0; c < 3000; c++) begin
            call_in = ($urandom_range(0, 7) == 0) ? NF'($urandom) : '0;
            rst = ($urandom_range(0, 599) == 0);
            tick(1);
        end
        rst = 1'b0;
        call_in = '0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
